// File: rtl/frac_dec_pkg.sv
// Shared definitions for the fractional-decimator coefficient controller:
// register addresses, CTRL/STATUS bit positions and the bank-swap FSM encoding.
package frac_dec_pkg;

    localparam int ADDR_CTRL   = 'hF0;
    localparam int ADDR_STATUS = 'hF1;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_BYPASS_BIT = 1;
    localparam int CTRL_COMMIT_BIT = 2;

    localparam int STATUS_PEND_BIT = 0;
    localparam int STATUS_BANK_BIT = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_SWAP = 2'd2
    } state_t;

endpackage

// File: rtl/frac_dec_apb_if.sv
// APB decode and response for the coefficient controller (purely combinational).
// COEF_READBACK_EN adds the shadow-bank readback path for the coefficient region.
module frac_dec_apb_if
    import frac_dec_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int TAPS_NUM   = 138,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                          psel,
    input  logic                          penable,
    input  logic                          pwrite,
    input  logic                          pready,
    input  logic [ADDR_WIDTH-1:0]         paddr,
    input  logic [DATA_WIDTH-1:0]         pwdata,
`ifdef COEF_READBACK_EN
    input  logic [DATA_WIDTH-1:0]         shadow_rdata,
`endif
    input  logic                          ctrl_en,
    input  logic                          ctrl_bypass,
    input  logic                          pending,
    input  logic                          active_bank,
    output logic [DATA_WIDTH-1:0]         prdata,
    output logic                          pslverr,
    output logic                          coef_wr,
    output logic [$clog2(TAPS_NUM)-1:0]   coef_addr,
    output logic [DATA_WIDTH-1:0]         wdata,
    output logic                          ctrl_wr,
    output logic                          commit
);

    localparam int IDX_W = $clog2(TAPS_NUM);

    logic access;
    logic is_coef;
    logic is_ctrl;
    logic is_status;
    logic unmapped;

    // An access completes only in the APB access phase while the FSM is not swapping.
    assign access    = psel & penable & pready;
    assign is_coef   = 32'(paddr) < TAPS_NUM;
    assign is_ctrl   = paddr == ADDR_WIDTH'(ADDR_CTRL);
    assign is_status = paddr == ADDR_WIDTH'(ADDR_STATUS);
    assign unmapped  = ~(is_coef | is_ctrl | is_status);

    assign coef_addr = IDX_W'(paddr);
    assign wdata     = pwdata;
    assign coef_wr   = access & pwrite & is_coef;
    assign ctrl_wr   = access & pwrite & is_ctrl;
    assign commit    = ctrl_wr & pwdata[CTRL_COMMIT_BIT];
    assign pslverr   = access & unmapped;

    always_comb begin
        prdata = '0;
        if (access && !pwrite) begin
            if (is_ctrl) begin
                prdata[CTRL_EN_BIT]     = ctrl_en;
                prdata[CTRL_BYPASS_BIT] = ctrl_bypass;
            end else if (is_status) begin
                prdata[STATUS_PEND_BIT] = pending;
                prdata[STATUS_BANK_BIT] = active_bank;
            end
`ifdef COEF_READBACK_EN
            else if (is_coef) begin
                prdata = shadow_rdata;
            end
`endif
        end
    end

endmodule

// File: rtl/frac_dec_coef_ctrl.sv
// Double-buffered coefficient store for the fractional decimator with an APB
// shadow bank and frame-aligned swap. Optional macro: COEF_READBACK_EN.
module frac_dec_coef_ctrl
    import frac_dec_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int TAPS_NUM   = 138,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          PSEL,
    input  logic                          PENABLE,
    input  logic                          PWRITE,
    input  logic [ADDR_WIDTH-1:0]         PADDR,
    input  logic [DATA_WIDTH-1:0]         PWDATA,
    output logic [DATA_WIDTH-1:0]         PRDATA,
    output logic                          PREADY,
    output logic                          PSLVERR,
    input  logic                          dp_valid,
    input  logic [$clog2(TAPS_NUM)-1:0]   coef_idx,
    output logic signed [DATA_WIDTH-1:0]  coef_data,
    output logic                          dp_en,
    output logic                          dp_bypass,
    output logic                          swap_irq
);

    localparam int IDX_W = $clog2(TAPS_NUM);

    state_t state;
    state_t state_next;

    logic                  active_sel;
    logic                  ctrl_en;
    logic                  ctrl_bypass;
    logic                  coef_wr;
    logic                  ctrl_wr;
    logic                  commit;
    logic [IDX_W-1:0]      coef_addr;
    logic [DATA_WIDTH-1:0] wdata;

    logic [DATA_WIDTH-1:0] bank0 [TAPS_NUM];
    logic [DATA_WIDTH-1:0] bank1 [TAPS_NUM];

    assign PREADY   = (state != ST_SWAP);
    assign swap_irq = (state == ST_SWAP);

`ifdef COEF_READBACK_EN
    logic [DATA_WIDTH-1:0] shadow_rdata;

    always_comb begin
        shadow_rdata = '0;
        if (32'(coef_addr) < TAPS_NUM) begin
            shadow_rdata = active_sel ? bank0[coef_addr] : bank1[coef_addr];
        end
    end
`endif

    frac_dec_apb_if #(
        .DATA_WIDTH (DATA_WIDTH),
        .TAPS_NUM   (TAPS_NUM),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_apb_if (
        .psel         (PSEL),
        .penable      (PENABLE),
        .pwrite       (PWRITE),
        .pready       (PREADY),
        .paddr        (PADDR),
        .pwdata       (PWDATA),
`ifdef COEF_READBACK_EN
        .shadow_rdata (shadow_rdata),
`endif
        .ctrl_en      (ctrl_en),
        .ctrl_bypass  (ctrl_bypass),
        .pending      (state != ST_IDLE),
        .active_bank  (active_sel),
        .prdata       (PRDATA),
        .pslverr      (PSLVERR),
        .coef_wr      (coef_wr),
        .coef_addr    (coef_addr),
        .wdata        (wdata),
        .ctrl_wr      (ctrl_wr),
        .commit       (commit)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Commits are only honoured from IDLE; a disabled datapath never delivers
    // dp_valid, so the swap proceeds without waiting for a frame boundary.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (commit) state_next = ST_PEND;
            ST_PEND: if (dp_valid || !dp_en) state_next = ST_SWAP;
            ST_SWAP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            active_sel  <= 1'b0;
            ctrl_en     <= 1'b0;
            ctrl_bypass <= 1'b0;
            dp_en       <= 1'b0;
            dp_bypass   <= 1'b0;
        end else begin
            if (state == ST_SWAP) begin
                active_sel <= ~active_sel;
            end
            if (ctrl_wr) begin
                ctrl_en     <= wdata[CTRL_EN_BIT];
                ctrl_bypass <= wdata[CTRL_BYPASS_BIT];
            end
            dp_en     <= ctrl_en;
            dp_bypass <= ctrl_bypass;
        end
    end

    // On the swap edge the bank about to become shadow is refreshed from the
    // bank about to become live. APB writes cannot collide: PREADY is low then.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < TAPS_NUM; i++) bank0[i] <= '0;
        end else if (state == ST_SWAP) begin
            if (!active_sel) begin
                for (int i = 0; i < TAPS_NUM; i++) bank0[i] <= bank1[i];
            end
        end else if (coef_wr && active_sel) begin
            bank0[coef_addr] <= wdata;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < TAPS_NUM; i++) bank1[i] <= '0;
        end else if (state == ST_SWAP) begin
            if (active_sel) begin
                for (int i = 0; i < TAPS_NUM; i++) bank1[i] <= bank0[i];
            end
        end else if (coef_wr && !active_sel) begin
            bank1[coef_addr] <= wdata;
        end
    end

    always_comb begin
        coef_data = '0;
        if (32'(coef_idx) < TAPS_NUM) begin
            coef_data = active_sel ? bank1[coef_idx] : bank0[coef_idx];
        end
    end

endmodule

// File: tb/tb_frac_dec_coef_ctrl.sv
// Scoreboard bench for frac_dec_coef_ctrl: directed scenarios plus randomized
// APB/datapath traffic checked against an abstract live/shadow bank model.
module tb_frac_dec_coef_ctrl;

    localparam int TAPS = 138;

    logic              CLK = 1'b0;
    logic              RST = 1'b0;
    logic              PSEL = 1'b0;
    logic              PENABLE = 1'b0;
    logic              PWRITE = 1'b0;
    logic [7:0]        PADDR = '0;
    logic [15:0]       PWDATA = '0;
    logic [15:0]       PRDATA;
    logic              PREADY;
    logic              PSLVERR;
    logic              dp_valid = 1'b0;
    logic [7:0]        coef_idx = '0;
    logic signed [15:0] coef_data;
    logic              dp_en;
    logic              dp_bypass;
    logic              swap_irq;

    frac_dec_coef_ctrl #(
        .DATA_WIDTH (16),
        .TAPS_NUM   (TAPS),
        .ADDR_WIDTH (8)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR),
        .dp_valid  (dp_valid),
        .coef_idx  (coef_idx),
        .coef_data (coef_data),
        .dp_en     (dp_en),
        .dp_bypass (dp_bypass),
        .swap_irq  (swap_irq)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        is_read;
        logic        err;
        logic [15:0] data;
    } apb_exp_t;

    typedef struct packed {
        logic [15:0] coef;
        logic        en;
        logic        byp;
    } probe_exp_t;

    apb_exp_t   apb_q[$];
    probe_exp_t probe_q[$];
    logic       probe_v = 1'b0;

    // Abstract model: what the datapath sees, what APB writes into, and the CTRL/STATUS view.
    logic [15:0] live_m   [TAPS];
    logic [15:0] shadow_m [TAPS];
    logic        en_m, byp_m, pending_m, bank_m;
    int          swaps_m = 0;
    int          irq_cnt = 0;
    int          total = 0;
    int          bad = 0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        apb_exp_t   e;
        probe_exp_t p;
        if (swap_irq === 1'b1) irq_cnt++;
        if (PSEL && PENABLE && PREADY) begin
            if (apb_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL apb_unexpected: access completed with no expectation queued");
            end else begin
                e = apb_q.pop_front();
                check_output("apb_pslverr", 32'(PSLVERR), 32'(e.err));
                if (e.is_read) check_output("apb_prdata", 32'(PRDATA), 32'(e.data));
            end
        end
        if (probe_v) begin
            if (probe_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL probe_unexpected: probe with no expectation queued");
            end else begin
                p = probe_q.pop_front();
                check_output("coef_data", 32'($unsigned(coef_data)), 32'(p.coef));
                check_output("dp_en", 32'(dp_en), 32'(p.en));
                check_output("dp_bypass", 32'(dp_bypass), 32'(p.byp));
            end
        end
    end

    function automatic void model_reset();
        for (int i = 0; i < TAPS; i++) begin
            live_m[i]   = '0;
            shadow_m[i] = '0;
        end
        en_m = 0; byp_m = 0; pending_m = 0; bank_m = 0;
    endfunction

    function automatic void model_swap();
        for (int i = 0; i < TAPS; i++) live_m[i] = shadow_m[i];
        pending_m = 0;
        bank_m    = ~bank_m;
        swaps_m++;
    endfunction

    function automatic logic is_unmapped(input logic [7:0] a);
        return (a >= TAPS) && (a != 8'hF0) && (a != 8'hF1);
    endfunction

    function automatic logic [15:0] model_read(input logic [7:0] a);
        logic [15:0] r;
        r = '0;
        if (a < TAPS) begin
`ifdef COEF_READBACK_EN
            r = shadow_m[a];
`else
            r = '0;
`endif
        end else if (a == 8'hF0) begin
            r = {14'd0, byp_m, en_m};
        end else if (a == 8'hF1) begin
            r = {14'd0, bank_m, pending_m};
        end
        return r;
    endfunction

    // Returns the number of negedges within which a swap must show up, or 0 if none is due.
    function automatic int model_write(input logic [7:0] a, input logic [15:0] d);
        int   budget;
        logic old_en;
        budget = 0;
        if (a < TAPS) begin
            shadow_m[a] = d;
        end else if (a == 8'hF0) begin
            old_en = en_m;
            en_m   = d[0];
            byp_m  = d[1];
            if (d[2] && !pending_m) begin
                pending_m = 1;
                if (!old_en) budget = 2;
                else if (!en_m) budget = 3;
            end else if (pending_m && !en_m) begin
                budget = 3;
            end
        end
        return budget;
    endfunction

    task automatic apb_access(input logic wr, input logic [7:0] a, input logic [15:0] d, output int waits);
        PSEL = 1; PWRITE = wr; PADDR = a; PWDATA = d; PENABLE = 0;
        @(posedge CLK); #1;
        PENABLE = 1;
        waits = 0;
        @(negedge CLK);
        while (!PREADY && waits < 8) begin
            waits++;
            @(negedge CLK);
        end
        if (!PREADY) begin
            total++;
            bad++;
            $display("[TB] FAIL apb_timeout: PREADY=%0b after %0d wait states, required 1", PREADY, waits);
        end
        @(posedge CLK); #1;
        PSEL = 0; PENABLE = 0; PWRITE = 0;
    endtask

    task automatic wait_swap(input int budget);
        int n;
        n = 0;
        while (irq_cnt != swaps_m && n < budget) begin
            @(negedge CLK); #1;
            n++;
        end
        check_output("swap_irq_cnt", 32'(irq_cnt), 32'(swaps_m));
        @(posedge CLK); #1;
    endtask

    task automatic apply_stimulus(input logic wr, input logic [7:0] a, input logic [15:0] d);
        apb_exp_t e;
        int       w;
        int       budget;
        e.is_read = !wr;
        e.err     = is_unmapped(a);
        e.data    = wr ? 16'h0 : model_read(a);
        apb_q.push_back(e);
        apb_access(wr, a, d, w);
        budget = 0;
        if (wr && !e.err) budget = model_write(a, d);
        if (budget > 0) begin
            model_swap();
            wait_swap(budget);
        end
    endtask

    task automatic probe_coef(input logic [7:0] idx);
        probe_exp_t p;
        @(posedge CLK); #1;
        p.coef = (idx < TAPS) ? live_m[idx] : 16'h0;
        p.en   = en_m;
        p.byp  = byp_m;
        probe_q.push_back(p);
        coef_idx = idx;
        probe_v  = 1;
        @(posedge CLK); #1;
        probe_v  = 0;
    endtask

    task automatic pulse_valid();
        logic do_swap;
        do_swap  = pending_m && en_m;
        dp_valid = 1;
        @(posedge CLK); #1;
        dp_valid = 0;
        if (do_swap) begin
            model_swap();
            wait_swap(1);
        end
    endtask

    function automatic logic [7:0] rand_unmapped();
        if ($urandom_range(0, 1) == 0) return 8'($urandom_range(TAPS, 'hEF));
        return 8'($urandom_range('hF2, 'hFF));
    endfunction

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int r;
        model_reset();

        // Outputs while reset is held.
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_output("rst_pready", 32'(PREADY), 32'd1);
        check_output("rst_pslverr", 32'(PSLVERR), 32'd0);
        check_output("rst_prdata", 32'(PRDATA), 32'd0);
        check_output("rst_dp_en", 32'(dp_en), 32'd0);
        check_output("rst_dp_bypass", 32'(dp_bypass), 32'd0);
        check_output("rst_swap_irq", 32'(swap_irq), 32'd0);
        @(posedge CLK); #1;
        RST = 1;

        apply_stimulus(0, 8'hF1, 0);
        for (int i = 0; i < TAPS; i++) probe_coef(8'(i));
        probe_coef(8'd200);

        // Shadow isolation.
        apply_stimulus(1, 8'd5, 16'h1234);
        probe_coef(8'd5);
        apply_stimulus(0, 8'hF1, 0);

        // Commit with the datapath enabled waits for a frame boundary.
        apply_stimulus(1, 8'hF0, 16'h0003);
        probe_coef(8'd5);
        apply_stimulus(1, 8'hF0, 16'h0007);
        repeat (5) apply_stimulus(0, 8'hF1, 0);
        probe_coef(8'd5);
        pulse_valid();
        probe_coef(8'd5);
        apply_stimulus(0, 8'hF1, 0);

        // Commit with the datapath disabled swaps without dp_valid.
        apply_stimulus(1, 8'hF0, 16'h0000);
        apply_stimulus(1, 8'd6, 16'h8111);
        apply_stimulus(1, 8'hF0, 16'h0004);
        probe_coef(8'd6);
        apply_stimulus(0, 8'hF1, 0);

        // Write whose access phase lands on the SWAP cycle.
        apply_stimulus(1, 8'hF0, 16'h0001);
        probe_coef(8'd7);
        apply_stimulus(1, 8'hF0, 16'h0005);
        begin : stalled_write
            apb_exp_t e;
            int       w;
            e.is_read = 0; e.err = 0; e.data = '0;
            apb_q.push_back(e);
            fork
                apb_access(1'b1, 8'd7, 16'hBEEF, w);
                begin
                    dp_valid = 1;
                    @(posedge CLK); #1;
                    dp_valid = 0;
                end
            join
            model_swap();
            shadow_m[7] = 16'hBEEF;
            check_output("stall_wait_states", 32'(w), 32'd1);
            check_output("stall_irq_cnt", 32'(irq_cnt), 32'(swaps_m));
        end
        probe_coef(8'd7);
        apply_stimulus(0, 8'd7, 0);
        apply_stimulus(1, 8'hF0, 16'h0005);
        pulse_valid();
        probe_coef(8'd7);

        // Unmapped and read-only addresses.
        apply_stimulus(1, 8'h90, 16'hFFFF);
        apply_stimulus(0, 8'h90, 0);
        apply_stimulus(0, 8'hF1, 0);
        apply_stimulus(0, 8'hF0, 0);
        apply_stimulus(1, 8'hF1, 16'h0003);
        apply_stimulus(0, 8'hF1, 0);
        probe_coef(8'd5);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            if (r < 30) begin
                if ($urandom_range(0, 9) == 0) apply_stimulus(1, rand_unmapped(), 16'($urandom));
                else apply_stimulus(1, 8'($urandom_range(0, TAPS - 1)), 16'($urandom));
            end else if (r < 50) begin
                case ($urandom_range(0, 3))
                    0: apply_stimulus(0, 8'($urandom_range(0, TAPS - 1)), 0);
                    1: apply_stimulus(0, 8'hF0, 0);
                    2: apply_stimulus(0, 8'hF1, 0);
                    default: apply_stimulus(0, rand_unmapped(), 0);
                endcase
            end else if (r < 65) begin
                if ($urandom_range(0, 7) == 0) probe_coef(8'($urandom_range(TAPS, 255)));
                else probe_coef(8'($urandom_range(0, TAPS - 1)));
            end else if (r < 80) begin
                apply_stimulus(1, 8'hF0, {13'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                          1'($urandom_range(0, 3) != 0)});
            end else if (r < 90) begin
                pulse_valid();
            end else begin
                apply_stimulus(0, 8'hF1, 0);
            end
        end
        if (pending_m) pulse_valid();

        // Reset while a swap is pending abandons it.
        apply_stimulus(1, 8'hF0, 16'h0001);
        apply_stimulus(1, 8'd3, 16'hA5A5);
        apply_stimulus(1, 8'hF0, 16'h0005);
        apply_stimulus(0, 8'hF1, 0);
        RST = 0;
        repeat (2) @(posedge CLK);
        #1;
        model_reset();
        RST = 1;
        apply_stimulus(0, 8'hF1, 0);
        apply_stimulus(0, 8'hF0, 0);
        probe_coef(8'd3);
        probe_coef(8'd5);
        probe_coef(8'd7);
        repeat (4) @(posedge CLK);
        #1;

        check_output("final_irq_cnt", 32'(irq_cnt), 32'(swaps_m));
        check_output("sb_leftover", 32'(apb_q.size() + probe_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frac_dec_coef_ctrl.md
FRAC_DEC_COEF_CTRL -- requirements
Module: frac_dec_coef_ctrl

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 16, coefficient width.
REQ-002 Parameters SHALL be: TAPS_NUM, default 138, coefficients per bank.
REQ-003 Parameters SHALL be: ADDR_WIDTH, default 8, APB word-address width.
REQ-004 Ports SHALL be: CLK, input, 1, clock.
REQ-005 Ports SHALL be: RST, input, 1, asynchronous active-low reset.
REQ-006 Ports SHALL be: PSEL, PENABLE, PWRITE, input, 1 each, APB control.
REQ-007 Ports SHALL be: PADDR, input, ADDR_WIDTH, APB word address.
REQ-008 Ports SHALL be: PWDATA, input, DATA_WIDTH, APB write data.
REQ-009 Ports SHALL be: PRDATA, output, DATA_WIDTH, APB read data.
REQ-010 Ports SHALL be: PREADY and PSLVERR, output, 1 each.
REQ-011 Ports SHALL be: dp_valid, input, 1, decimator output-valid strobe (frame boundary).
REQ-012 Ports SHALL be: coef_idx, input, ceil(log2 TAPS_NUM), datapath tap index.
REQ-013 Ports SHALL be: coef_data, output, DATA_WIDTH signed, active-bank coefficient at coef_idx, combinational.
REQ-014 Ports SHALL be: dp_en and dp_bypass, output, 1 each, decimator EN and bypass.
REQ-015 Ports SHALL be: swap_irq, output, 1, one-cycle pulse on bank swap.

Function
REQ-016 Register map SHALL be: 0..TAPS_NUM-1 = shadow coefficients (R/W); 0xF0 CTRL (bit0 enable, bit1 bypass, bit2 commit, write-1 self-clearing); 0xF1 STATUS (RO: bit0 pending, bit1 active bank).
REQ-017 There SHALL be two coefficient banks: APB writes always target the shadow bank, and the datapath always reads the active bank.
REQ-018 A write with PSEL&PENABLE&PWRITE&PREADY SHALL take effect on that clock edge.
REQ-019 PREADY SHALL be 1 except during the SWAP state, when it SHALL be 0; this gives exactly one wait state for any access that overlaps SWAP.
REQ-020 An access to an unmapped address SHALL complete with PSLVERR=1, writes to it SHALL be ignored, and reads of it SHALL return 0.
REQ-021 The FSM SHALL have three states: IDLE, PEND and SWAP.
REQ-022 In IDLE, writing commit=1 SHALL move the FSM to PEND.
REQ-023 In PEND, the FSM SHALL move to SWAP on the first cycle with dp_valid=1, or with dp_en=0.
REQ-024 SWAP SHALL last one cycle, SHALL toggle the active-bank select, SHALL copy the new active bank into the new shadow bank, SHALL pulse swap_irq, and SHALL then return to IDLE.
REQ-025 The copy SHALL be a full-width parallel register copy, so the shadow bank starts equal to the live bank.
REQ-026 A commit written while in PEND or SWAP SHALL be ignored.
REQ-027 A coefficient write in the same cycle as the SWAP entry edge SHALL be stalled by PREADY=0 and SHALL land in the new shadow bank.
REQ-028 dp_en and dp_bypass SHALL follow CTRL with a one-cycle register delay.
REQ-029 coef_data SHALL return 0 when coef_idx >= TAPS_NUM.

Reset
REQ-030 On RST low, the controller SHALL set: both banks zero, active bank 0, FSM IDLE, CTRL 0, dp_en 0, dp_bypass 0, swap_irq 0, PREADY 1, PSLVERR 0, PRDATA 0.
REQ-031 A reset during PEND or SWAP SHALL abandon the pending swap with no partial bank update.

Configuration
REQ-032 With COEF_READBACK_EN defined, APB reads of the coefficient region SHALL return the shadow-bank word.
REQ-033 Without COEF_READBACK_EN, APB reads of the coefficient region SHALL return 0 with PSLVERR=0, and the readback mux SHALL be absent.

Structure
REQ-034 A shared package frac_dec_pkg SHALL hold the register addresses (CTRL 0xF0, STATUS 0xF1), the CTRL bit positions, and the FSM state encoding.
REQ-035 The APB decode and response logic SHALL be one sub-module, frac_dec_apb_if; the bank storage and FSM SHALL stay in the top level.

Verification
REQ-036 Reset check: after reset release, STATUS reads 0, and coef_data=0 for coef_idx=0..137.
REQ-037 Shadow isolation: write 0x1234 at address 5, then set coef_idx=5 -> coef_data stays 0 while STATUS.pending=0.
REQ-038 Commit with enable: with dp_en=1, write CTRL=0x7, then pulse dp_valid 10 cycles later -> pending=1 during the wait; SWAP on the dp_valid cycle; coef_data(5)=0x1234 and swap_irq pulses once.
REQ-039 Commit while disabled: with enable=0, write commit -> swap occurs within 2 cycles with no dp_valid.
REQ-040 Stalled write: write to address 7 on the SWAP cycle -> PREADY=0 for one cycle, and the value appears in the new shadow bank, not the active bank.
REQ-041 Unmapped address: write 0x90 -> PSLVERR=1; a read returns 0; no state changes.
